fp_calc_issue: RTL and testbench
================================

FP_CALC_ISSUE -- requirements
Module: fp_calc_issue

Interface
REQ-001 Parameter ADDSUB_LAT, default 1, number of RUN cycles before an add/sub result is captured (min 1).
REQ-002 Parameter MUL_LAT, default 2, number of RUN cycles before a multiply result is captured (min 1).
REQ-003 Parameter TIMEOUT, default 255, maximum number of RUN cycles spent waiting for a divide to finish (8-bit counter).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_a, req_b  input  32  IEEE-754 single operands.
REQ-009 req_op  input  2  00 add, 01 subtract, 10 multiply, 11 divide.
REQ-010 calc_a, calc_b  output  32  operands driven to the calculator.
REQ-011 calc_op  output  2  operation driven to the calculator.
REQ-012 calc_en  output  1  calculator enable.
REQ-013 calc_rst_n  output  1  calculator reset, active-low.
REQ-014 calc_out  input  32  calculator result.
REQ-015 calc_finish  input  1  calculator completion flag.
REQ-016 res_valid  output  1  result available.
REQ-017 res_ready  input  1  consumer accepts result.
REQ-018 res_data  output  32  captured result.
REQ-019 res_op  output  2  opcode of the captured result.
REQ-020 res_timeout  output  1  result is a timeout substitute.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, CLEAR, RUN and HOLD, encoded in registers.
REQ-023 req_ready SHALL be 1 only in IDLE with rst_n high; a handshake is req_valid&req_ready at a clock edge.
REQ-024 IDLE: on handshake, register req_a/req_b/req_op into calc_a/calc_b/calc_op and go to CLEAR; otherwise stay; req_valid outside IDLE is ignored.
REQ-025 CLEAR: lasts exactly 1 cycle; calc_rst_n=0, calc_en=0; run counter cleared; next state RUN.
REQ-026 RUN: calc_en=1, calc_rst_n=1; counter increments by 1 per RUN cycle, saturating at TIMEOUT.
REQ-027 RUN exit for op 00/01 occurs at the edge ending the ADDSUB_LAT-th RUN cycle; for op 10 at the edge ending the MUL_LAT-th RUN cycle; for op 11 at the first edge with calc_finish=1.
REQ-028 On RUN exit, capture calc_out into res_data and calc_op into res_op, clear res_timeout, set res_valid, and go to HOLD.
REQ-029 Divide timeout: if the counter equals TIMEOUT with calc_finish=0, capture res_data=32'h7FC00000 (qNaN), set res_timeout=1 and res_valid=1, and go to HOLD.
REQ-030 If calc_finish=1 and the timeout condition occur in the same cycle, calc_finish SHALL win and res_timeout SHALL be 0.
REQ-031 calc_finish SHALL be ignored outside RUN and for ops 00/01/10.
REQ-032 HOLD: calc_en=0; res_data/res_op/res_timeout stable; res_valid=1 until an edge with res_ready=1, then res_valid=0 and go to IDLE.
REQ-033 No new request is accepted in the HOLD-exit cycle; the earliest next accept is the following cycle.
REQ-034 calc_a/calc_b/calc_op SHALL remain stable from the CLEAR entry until the next handshake.
REQ-035 Latency from the accepting edge to res_valid high SHALL be 2+ADDSUB_LAT edges (add/sub), 2+MUL_LAT edges (mul), and 2+N edges for a divide finishing in RUN cycle N.

Reset
REQ-036 While rst_n=0, the block SHALL immediately force: state IDLE, req_ready=0, calc_en=0, calc_rst_n=0, calc_a/calc_b/calc_op=0, counter 0, res_valid=0, res_data=0, res_op=0, res_timeout=0, busy=0.
REQ-037 Reset asserted in any state, including mid-RUN, SHALL abort the operation and discard it; no res_valid pulse results.
REQ-038 After rst_n rises, the first handshake SHALL be possible at the first clock edge.

Verification
REQ-039 add: req_a=0x3F800000, req_b=0x40000000, op=00, calc_out stub=0x40400000 -> res_valid 3 edges after accept, res_data=0x40400000, res_op=00, res_timeout=0.
REQ-040 mul (MUL_LAT=2): 0x40000000*0x40400000, stub 0x40C00000 -> res_valid 4 edges after accept; calc_en high exactly 2 cycles.
REQ-041 div: stub raises calc_finish in RUN cycle 20 with 0x3F000000 -> res_valid 22 edges after accept; res_data=0x3F000000; calc_rst_n low exactly 1 cycle before RUN.
REQ-042 div timeout: calc_finish never asserted -> after 255 RUN cycles, res_data=0x7FC00000, res_timeout=1; a repeat run with finish in cycle 255 -> res_timeout=0.
REQ-043 backpressure: res_ready held low 5 cycles with req_valid high throughout -> res_valid/res_data stable, req_ready=0, no second accept until 1 cycle after the result handshake.
REQ-044 reset mid-RUN during a divide -> all outputs at reset values asynchronously, no res_valid; the next request completes normally.

Source files
------------

// File: rtl/fp_calc_issue.sv
// Issue controller for an external FP calculator: accepts one request, clears and
// runs the calculator for an op-dependent time, then holds the result for the consumer.
module fp_calc_issue #(
    parameter int ADDSUB_LAT = 1,
    parameter int MUL_LAT    = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic [1:0]  calc_op,
    output logic        calc_en,
    output logic        calc_rst_n,
    input  logic [31:0] calc_out,
    input  logic        calc_finish,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [1:0]  res_op,
    output logic        res_timeout,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_HOLD} state_t;

    localparam logic [7:0]  C_ADDSUB_LAT = 8'(ADDSUB_LAT);
    localparam logic [7:0]  C_MUL_LAT    = 8'(MUL_LAT);
    localparam logic [7:0]  C_TIMEOUT    = 8'(TIMEOUT);
    localparam logic [31:0] C_QNAN       = 32'h7FC0_0000;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_run_cycle;
    logic [31:0] r_calc_a;
    logic [31:0] r_calc_b;
    logic [1:0]  r_calc_op;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic [1:0]  r_res_op;
    logic        r_res_timeout;
    logic        w_accept;
    logic        w_done;
    logic        w_timeout;

    // r_cnt holds completed RUN cycles, so w_run_cycle is the 1-based index of the current one.
    assign w_run_cycle = (r_cnt == C_TIMEOUT) ? r_cnt : r_cnt + 8'd1;

    // Gating with rst_n keeps req_ready low for the whole reset, not just after the state settles.
    assign req_ready  = rst_n && (r_state == S_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign calc_en    = (r_state == S_RUN);
    assign calc_rst_n = rst_n && (r_state != S_CLEAR);
    assign busy       = (r_state != S_IDLE);

    assign calc_a      = r_calc_a;
    assign calc_b      = r_calc_b;
    assign calc_op     = r_calc_op;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_op      = r_res_op;
    assign res_timeout = r_res_timeout;

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CLEAR;
            S_CLEAR: w_next = S_RUN;
            S_RUN: begin
                case (r_calc_op)
                    2'b00, 2'b01: w_done = (w_run_cycle >= C_ADDSUB_LAT);
                    2'b10:        w_done = (w_run_cycle >= C_MUL_LAT);
                    default: begin
                        // A finish in the timeout cycle still counts as a real result.
                        if (calc_finish)                    w_done    = 1'b1;
                        else if (w_run_cycle >= C_TIMEOUT) w_timeout = 1'b1;
                    end
                endcase
                if (w_done || w_timeout) w_next = S_HOLD;
            end
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and resets asynchronously on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_calc_a      <= '0;
            r_calc_b      <= '0;
            r_calc_op     <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_op      <= '0;
            r_res_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_calc_a  <= req_a;
                        r_calc_b  <= req_b;
                        r_calc_op <= req_op;
                    end
                end
                S_CLEAR: r_cnt <= '0;
                S_RUN: begin
                    r_cnt <= w_run_cycle;
                    if (w_done) begin
                        r_res_data    <= calc_out;
                        r_res_op      <= r_calc_op;
                        r_res_timeout <= 1'b0;
                        r_res_valid   <= 1'b1;
                    end else if (w_timeout) begin
                        r_res_data    <= C_QNAN;
                        r_res_op      <= r_calc_op;
                        r_res_timeout <= 1'b1;
                        r_res_valid   <= 1'b1;
                    end
                end
                S_HOLD:  if (res_ready) r_res_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_calc_issue.sv
// Scoreboard bench for fp_calc_issue with a stub calculator whose finish cycle is programmable.
module tb_fp_calc_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_op;
    logic [31:0] calc_a;
    logic [31:0] calc_b;
    logic [1:0]  calc_op;
    logic        calc_en;
    logic        calc_rst_n;
    logic [31:0] calc_out;
    logic        calc_finish;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [1:0]  res_op;
    logic        res_timeout;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  op;
        logic        to;
    } exp_t;

    exp_t        sb[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] stub_out;
    int          stub_fin;
    int          run_cnt;

    fp_calc_issue dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .calc_a(calc_a), .calc_b(calc_b), .calc_op(calc_op),
        .calc_en(calc_en), .calc_rst_n(calc_rst_n),
        .calc_out(calc_out), .calc_finish(calc_finish),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub calculator: counts enabled cycles since its reset, finishes in cycle stub_fin.
    always @(posedge clk or negedge calc_rst_n) begin
        if (!calc_rst_n)  run_cnt <= 0;
        else if (calc_en) run_cnt <= run_cnt + 1;
    end
    assign calc_finish = calc_en && (stub_fin != 0) && (run_cnt + 1 == stub_fin);
    assign calc_out    = stub_out;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge: drives a request, accepts it on the next edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input exp_t e);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        #1 check("req_ready", req_ready, 1);
        sb.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("calc_a", calc_a, a);
        check("calc_b", calc_b, b);
        check("calc_op", calc_op, op);
    endtask

    // Counts edges from the accept edge (edge 1) until res_valid; ends at that negedge.
    task automatic wait_res(input int exp_lat);
        int lat = 1;
        int en  = 0;
        int clr = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            en  += int'(calc_en);
            clr += int'(!calc_rst_n);
            @(posedge clk);
            lat++;
        end
        check("res_valid_seen", seen, 1);
        check("latency", lat, exp_lat);
        check("calc_en_cycles", en, exp_lat - 2);
        check("calc_clear_cycles", clr, 1);
    endtask

    // At a negedge with res_valid high and res_ready high: compare and complete handshake.
    task automatic take_res();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            check("res_data", res_data, e.data);
            check("res_op", res_op, e.op);
            check("res_timeout", res_timeout, e.to);
        end
        @(posedge clk);
        #1 check("res_valid_drop", res_valid, 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] out, input int fin, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_to);
        stub_out = out;
        stub_fin = fin;
        @(negedge clk);
        issue(a, b, op, '{data: exp_data, op: op, to: exp_to});
        wait_res(exp_lat);
        take_res();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        res_ready = 1'b1; stub_out = '0; stub_fin = 0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_calc_rst_n", calc_rst_n, 0);
        check("rst_res_valid", res_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h3F80_0000, 32'h4000_0000, 2'b00, 32'h4040_0000, 1, 3, 32'h4040_0000, 1'b0);
        run_op(32'h4040_0000, 32'h3F80_0000, 2'b01, 32'h4000_0000, 0, 3, 32'h4000_0000, 1'b0);
        // Finish in RUN cycle 1 must not shorten a multiply.
        run_op(32'h4000_0000, 32'h4040_0000, 2'b10, 32'h40C0_0000, 1, 4, 32'h40C0_0000, 1'b0);
        run_op(32'h3F80_0000, 32'h4000_0000, 2'b11, 32'h3F00_0000, 20, 22, 32'h3F00_0000, 1'b0);
        run_op(32'h3F80_0000, 32'h0000_0000, 2'b11, 32'h1111_1111, 0, 257, 32'h7FC0_0000, 1'b1);
        run_op(32'h3F80_0000, 32'h4080_0000, 2'b11, 32'h3E80_0000, 255, 257, 32'h3E80_0000, 1'b0);

        // Backpressure with a second request waiting throughout.
        res_ready = 1'b0;
        stub_out  = 32'h4110_0000;
        stub_fin  = 0;
        @(negedge clk);
        issue(32'h4000_0000, 32'h40E0_0000, 2'b00, '{data: 32'h4110_0000, op: 2'b00, to: 1'b0});
        wait_res(3);
        held      = res_data;
        req_valid = 1'b1;
        req_a     = 32'hC000_0000;
        req_b     = 32'h4040_0000;
        req_op    = 2'b10;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_res_valid", res_valid, 1);
            check("bp_res_data", res_data, held);
            check("bp_req_ready", req_ready, 0);
            check("bp_calc_a", calc_a, 32'h4000_0000);
        end
        res_ready = 1'b1;
        take_res();
        check("bp_no_accept_in_exit", calc_op, 2'b00);
        sb.push_back('{data: 32'h4110_0000, op: 2'b10, to: 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp_second_calc_op", calc_op, 2'b10);
        check("bp_second_calc_a", calc_a, 32'hC000_0000);
        wait_res(4);
        take_res();

        // Reset in the middle of a divide.
        stub_fin = 0;
        @(negedge clk);
        issue(32'h4120_0000, 32'h4040_0000, 2'b11, '{data: 32'h0, op: 2'b11, to: 1'b0});
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_req_ready", req_ready, 0);
        check("mid_calc_en", calc_en, 0);
        check("mid_calc_rst_n", calc_rst_n, 0);
        check("mid_calc_a", calc_a, 0);
        check("mid_calc_op", calc_op, 0);
        check("mid_res_valid", res_valid, 0);
        check("mid_res_data", res_data, 0);
        check("mid_res_timeout", res_timeout, 0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("mid_no_res_valid", res_valid, 0);
        end
        rst_n    = 1'b1;
        stub_out = 32'h4080_0000;
        issue(32'h4000_0000, 32'h4000_0000, 2'b00, '{data: 32'h4080_0000, op: 2'b00, to: 1'b0});
        wait_res(3);
        take_res();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
